// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - fetch-to-decode decoupling queue with redirect flush
module if_id_fetch_queue #(
  parameter int unsigned        DEPTH    = 2,
  parameter int unsigned        PC_W     = 64,
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 'h13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [PC_W-1:0]          in_dnpc,
  input  logic                     in_not_jump,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic [PC_W-1:0]          out_dnpc,
  output logic                     out_not_jump,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       stall_q, stall_d;

  // Payload storage is deliberately left unreset; outputs are masked while empty.
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   dnpc_mem [DEPTH];
  logic              nj_mem   [DEPTH];

  logic push;
  logic pop;

  // Ready depends only on registered occupancy, so decode never loops back into fetch.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign count     = count_q;
  assign stall_cnt = stall_q;

  // Next-state for pointers, occupancy and the stall counter; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A refused fetch is counted even during a flush cycle; saturates instead of wrapping.
    if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Payload write on an accepted push; a flush cycle writes nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
      dnpc_mem[wr_ptr_q] <= in_dnpc;
      nj_mem[wr_ptr_q]   <= in_not_jump;
    end
  end

  // Head presentation: stored entry when valid, otherwise a harmless NOP bundle.
  always_comb begin
    out_pc       = '0;
    out_inst     = NOP_INST;
    out_dnpc     = '0;
    out_not_jump = 1'b0;
    if (out_valid) begin
      out_pc       = pc_mem[rd_ptr_q];
      out_inst     = inst_mem[rd_ptr_q];
      out_dnpc     = dnpc_mem[rd_ptr_q];
      out_not_jump = nj_mem[rd_ptr_q];
    end
  end

endmodule
